// File: rtl/additive_inverse_sequencer.sv
// On-chip driver/checker for the additive-inverse processor: resets it, plays the
// seven-step immediate program for a latched operand, then checks y/zero against -operand.
//
//  state | meaning
//  IDLE  | processor held in reset, waiting for start
//  PRST  | one-cycle processor reset after an accepted start
//  S0-S6 | program steps, one immediate per cycle
//  CHECK | sample y/zero/x and score the run
//  DONE  | done pulse, processor back in reset
module additive_inverse_sequencer #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] operand,
    output logic             proc_reset,
    output logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic             zero_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] x_seen,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [3:0] {
        IDLE, PRST, S0, S1, S2, S3, S4, S5, S6, CHECK, DONE
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] op_q;
    logic [WIDTH-1:0] exp_y;
    logic             exp_zero;
    logic             match;
    logic             proc_reset_nx, busy_nx, done_nx;
    logic [WIDTH-1:0] imm_nx;

    assign exp_y    = ~op_q + {{(WIDTH-1){1'b0}}, 1'b1};
    assign exp_zero = (op_q == '0);
    assign match    = (y_in == exp_y) && (zero_in == exp_zero);

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        state_nx      = state;
        proc_reset_nx = 1'b0;
        busy_nx       = 1'b1;
        done_nx       = 1'b0;
        imm_nx        = '0;
        case (state)
            IDLE:    if (start) state_nx = PRST;
            PRST:    state_nx = S0;
            S0:      state_nx = S1;
            S1:      state_nx = S2;
            S2:      state_nx = S3;
            S3:      state_nx = S4;
            S4:      state_nx = S5;
            S5:      state_nx = S6;
            S6:      state_nx = CHECK;
            CHECK:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        case (state_nx)
            IDLE: begin
                proc_reset_nx = 1'b1;
                busy_nx       = 1'b0;
            end
            PRST:    proc_reset_nx = 1'b1;
            S0, S5:  imm_nx = op_q;
            S3:      imm_nx = {{(WIDTH-1){1'b0}}, 1'b1};
            DONE: begin
                proc_reset_nx = 1'b1;
                done_nx       = 1'b1;
            end
            default: imm_nx = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            op_q       <= '0;
            proc_reset <= 1'b1;
            imm        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            proc_reset <= proc_reset_nx;
            imm        <= imm_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            if (state == IDLE && start)
                op_q <= operand;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pass      <= 1'b0;
            result    <= '0;
            x_seen    <= '0;
            err_count <= '0;
        end else if (state == CHECK) begin
            result <= y_in;
            x_seen <= x_in;
            pass   <= match;
            if (!match && err_count != {ERR_W{1'b1}})
                err_count <= err_count + {{(ERR_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_additive_inverse_sequencer.sv
// Bench for additive_inverse_sequencer: directed and randomized runs against a
// behavioural processor model and an arithmetic reference for -operand mod 16.
module tb_additive_inverse_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] operand;
    logic       proc_reset;
    logic [3:0] imm;
    logic [3:0] x_in;
    logic [3:0] y_in;
    logic       zero_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] result;
    logic [3:0] x_seen;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;
    int ref_err = 0;

    logic [3:0] x_drive = 4'd0;
    bit         force_en = 1'b0;
    logic [3:0] force_y = 4'd0;

    int         cnt = 0;
    logic [3:0] first_imm = 4'd0;
    logic [3:0] model_y;

    additive_inverse_sequencer #(.WIDTH(4), .ERR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .operand(operand),
        .proc_reset(proc_reset), .imm(imm), .x_in(x_in), .y_in(y_in),
        .zero_in(zero_in), .busy(busy), .done(done), .pass(pass),
        .result(result), .x_seen(x_seen), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Processor model: after seven program steps y holds the negation of the first immediate.
    always @(posedge clk) begin
        if (proc_reset) cnt <= 0;
        else begin
            if (cnt == 0) first_imm <= imm;
            if (cnt < 100) cnt <= cnt + 1;
        end
    end
    assign model_y = 4'((16 - int'(first_imm)) % 16);
    assign y_in    = force_en ? force_y : ((cnt >= 7) ? model_y : 4'd0);
    assign zero_in = (y_in == 4'd0);
    assign x_in    = x_drive;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [3:0] op, input bit fault, input logic [3:0] fy, input bit glitch);
        logic [3:0] ref_y;
        logic [3:0] exp_imm [7];
        ref_y   = 4'((16 - int'(op)) % 16);
        exp_imm = '{op, 4'd0, 4'd0, 4'd1, 4'd0, op, 4'd0};
        x_drive  = 4'($urandom);
        force_en = fault;
        force_y  = fy;
        operand  = op;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        operand = 4'($urandom);
        if (fault && ref_err != 255) ref_err++;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (glitch && k == 5)  start = 1'b1;
            if (glitch && k == 6)  start = 1'b0;
            if (glitch && k == 10) start = 1'b1;
            chk("busy", busy, 1);
            chk("proc_reset", proc_reset, (k == 1 || k == 10) ? 1 : 0);
            chk("imm", imm, (k >= 2 && k <= 8) ? exp_imm[k-2] : 4'd0);
            chk("done", done, (k == 10) ? 1 : 0);
            if (k == 10) begin
                chk("pass", pass, fault ? 0 : 1);
                chk("result", result, fault ? fy : ref_y);
                chk("x_seen", x_seen, x_drive);
                chk("err_count", err_count, ref_err);
            end
        end
        @(negedge clk);
        if (glitch) start = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_proc_reset", proc_reset, 1);
        if (glitch) begin
            @(negedge clk);
            chk("glitch_ignored_busy", busy, 0);
        end
        force_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] op;
        logic [3:0] fy;
        bit         f;
        reset   = 1'b0;
        start   = 1'b0;
        operand = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_proc_reset", proc_reset, 1);
        chk("rst_imm", imm, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_result", result, 0);
        chk("rst_x_seen", x_seen, 0);
        chk("rst_err_count", err_count, 0);
        reset = 1'b1;
        @(negedge clk);

        run(4'd5, 1'b0, 4'd0, 1'b0);
        run(4'd0, 1'b0, 4'd0, 1'b0);
        run(4'd8, 1'b0, 4'd0, 1'b0);
        run(4'd5, 1'b1, 4'd3, 1'b0);
        run(4'd5, 1'b0, 4'd0, 1'b0);
        run(4'd2, 1'b0, 4'd0, 1'b1);

        for (int i = 0; i < 20; i++) begin
            op = 4'($urandom);
            f  = ($urandom_range(0, 3) == 0);
            fy = 4'(((16 - int'(op)) % 16 + 1 + int'($urandom_range(0, 14))) % 16);
            run(op, f, fy, 1'b0);
        end

        // Abort a run during S4 (cycle 6 after acceptance).
        operand = 4'd6;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_pre_busy", busy, 1);
        reset = 1'b0;
        #1;
        chk("abort_proc_reset", proc_reset, 1);
        chk("abort_imm", imm, 0);
        chk("abort_busy", busy, 0);
        chk("abort_err_count", err_count, 0);
        ref_err = 0;
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        reset = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_abort_done", done, 0);
            chk("post_abort_busy", busy, 0);
        end
        chk("post_abort_err", err_count, 0);

        run(4'd7, 1'b0, 4'd0, 1'b0);

        for (int i = 0; i < 260; i++) begin
            op = 4'($urandom);
            fy = 4'(((16 - int'(op)) % 16 + 1 + int'($urandom_range(0, 14))) % 16);
            run(op, 1'b1, fy, 1'b0);
        end
        chk("sat_err_count", err_count, 255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
